// File: rtl/corelet_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : corelet_seq_pkg
// Description : Shared types and constants for the corelet instruction
//               sequencer: state encoding, inst_w codes, flush length.
// Revision    : 1.0 - initial release
// ============================================================================
package corelet_seq_pkg;

    // Sequencer states; explicit 3-bit encoding
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_LGAP    = 3'd2,
        S_EXEC    = 3'd3,
        S_FLUSH   = 3'd4,
        S_READOUT = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // Instruction codes presented to the corelet
    localparam logic [2:0] c_INST_IDLE = 3'b000;
    localparam logic [2:0] c_INST_LOAD = 3'b001;
    localparam logic [2:0] c_INST_EXEC = 3'b010;

    // Extra drain cycles beyond the array diagonal (row + col)
    localparam int c_FLUSH_PAD = 4;

    // Cycles needed to drain the MAC array into the OFIFO/SFU
    function automatic int flush_len(input int rows, input int cols);
        return rows + cols + c_FLUSH_PAD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/corelet_seq_counter.sv
`default_nettype none
// ============================================================================
// Module      : seq_counter
// Description : Loadable phase counter with terminal-count flag. The count
//               reloads when `load` is high and otherwise increments; `tc`
//               flags that the count equals `last`.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] last,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    logic [WIDTH-1:0] r_count;

    // Phase count: reload on request, otherwise step by one
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;
    assign tc    = (r_count == last);

endmodule
`default_nettype wire

// File: rtl/corelet_seq.sv
`default_nettype none
// ============================================================================
// Module      : corelet_seq
// Description : Weight-stationary instruction sequencer for the corelet.
//               Reads kernel weights and activations from xmem, issues the
//               aligned load/execute stream, steps kij over all kernel
//               positions and pulses readout_start after the last flush.
//               Optional macro CORELET_SEQ_PERF_EN adds a 16-bit saturating
//               busy-cycle counter on port cycle_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module corelet_seq
    import corelet_seq_pkg::*;
#(
    parameter int BW          = 4,
    parameter int ROW         = 8,
    parameter int COL         = 8,
    parameter int N_ACT       = 36,
    parameter int N_KIJ       = 9,
    parameter int A_BW        = 11,
    parameter int W_BASE      = 1024,
    parameter int READOUT_CYC = 18
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                cen_xmem,
    output logic                wen_xmem,
    output logic [A_BW-1:0]     A_xmem,
    input  logic [ROW*BW-1:0]   Q_xmem,
    output logic [2:0]          inst_w,
    output logic [ROW*BW-1:0]   vector_data_in,
    output logic [3:0]          kij,
    output logic                readout_start,
    output logic                busy,
    output logic                done
`ifdef CORELET_SEQ_PERF_EN
    ,
    output logic [15:0]         cycle_cnt
`endif
);

    localparam int c_CW    = 16;
    localparam int c_FLUSH = flush_len(ROW, COL);

    // Weight addresses must fit in the xmem address space
    if (W_BASE + N_KIJ * COL > (1 << A_BW)) begin : g_param_check
        $error("corelet_seq: W_BASE + N_KIJ*COL exceeds xmem address space");
    end

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_kij;
    logic [2:0]        r_inst_w;
    logic [c_CW-1:0]   w_c;
    logic              w_tc;
    logic [c_CW-1:0]   w_last;
    logic              w_c_load;
    logic              w_last_kij;
    logic              w_start_ok;

    assign w_last_kij = (r_kij == 4'(N_KIJ - 1));
    assign w_start_ok = (r_state == S_IDLE) && start;

    // Phase counter; restarts at zero on every state change
    assign w_c_load = (w_state_next != r_state) || (r_state == S_IDLE);

    seq_counter #(
        .WIDTH (c_CW)
    ) u_phase_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (w_c_load),
        .load_val ('0),
        .last     (w_last),
        .count    (w_c),
        .tc       (w_tc)
    );

    // Terminal count for the current phase
    always_comb begin
        w_last = '0;
        case (r_state)
            S_LOAD:    w_last = c_CW'(COL - 1);
            S_LGAP:    w_last = c_CW'(COL - 1);
            S_EXEC:    w_last = c_CW'(N_ACT - 1);
            S_FLUSH:   w_last = c_CW'(c_FLUSH - 1);
            S_READOUT: w_last = c_CW'(READOUT_CYC - 1);
            default:   w_last = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_next = S_LOAD;
            S_LOAD:    if (w_tc)  w_state_next = S_LGAP;
            S_LGAP:    if (w_tc)  w_state_next = S_EXEC;
            S_EXEC:    if (w_tc)  w_state_next = S_FLUSH;
            S_FLUSH:   if (w_tc)  w_state_next = w_last_kij ? S_READOUT : S_LOAD;
            S_READOUT: if (w_tc)  w_state_next = S_DONE;
            S_DONE:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Kernel index: cleared on start, advanced only at FLUSH->LOAD so
    // no in-flight execute beat ever sees a changed kij
    always_ff @(posedge clk) begin
        if (reset) begin
            r_kij <= '0;
        end else if (w_start_ok) begin
            r_kij <= '0;
        end else if ((r_state == S_FLUSH) && w_tc && !w_last_kij) begin
            r_kij <= r_kij + 4'd1;
        end
    end

    // inst_w lags the address by one cycle so it lines up with Q_xmem
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inst_w <= c_INST_IDLE;
        end else begin
            case (r_state)
                S_LOAD:  r_inst_w <= c_INST_LOAD;
                S_EXEC:  r_inst_w <= c_INST_EXEC;
                default: r_inst_w <= c_INST_IDLE;
            endcase
        end
    end

    // Output decode from state and counter registers only
    always_comb begin
        cen_xmem      = 1'b1;
        A_xmem        = '0;
        readout_start = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_LOAD: begin
                cen_xmem = 1'b0;
                A_xmem   = A_BW'(W_BASE) + A_BW'(r_kij) * A_BW'(COL) + A_BW'(w_c);
            end
            S_EXEC: begin
                cen_xmem = 1'b0;
                A_xmem   = A_BW'(w_c);
            end
            S_READOUT: begin
                readout_start = (w_c == '0);
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: begin
                cen_xmem = 1'b1;
            end
        endcase
    end

    assign wen_xmem       = 1'b1;
    assign inst_w         = r_inst_w;
    assign kij            = r_kij;
    assign vector_data_in = Q_xmem;

`ifdef CORELET_SEQ_PERF_EN
    logic [15:0] r_cycle_cnt;

    // Busy-cycle counter: cleared per run, saturating, held after DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_cnt <= '0;
        end else if (w_start_ok) begin
            r_cycle_cnt <= '0;
        end else if (busy && (r_cycle_cnt != 16'hFFFF)) begin
            r_cycle_cnt <= r_cycle_cnt + 16'd1;
        end
    end

    assign cycle_cnt = r_cycle_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_corelet_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_corelet_seq
// Description : Self-checking bench for corelet_seq with a behavioural xmem
//               and a per-cycle expected schedule built from the phase
//               lengths of a run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_corelet_seq;

    localparam int BW       = 4;
    localparam int ROW      = 8;
    localparam int COL      = 8;
    localparam int N_ACT    = 36;
    localparam int N_KIJ    = 9;
    localparam int A_BW     = 11;
    localparam int W_BASE   = 1024;
    localparam int RCYC     = 18;
    localparam int PER_KIJ  = COL + COL + N_ACT + (ROW + COL + 4);
    localparam int RUN_LEN  = N_KIJ * PER_KIJ + RCYC;
    localparam int N_SCHED  = RUN_LEN + 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                cen_xmem;
    logic                wen_xmem;
    logic [A_BW-1:0]     A_xmem;
    logic [ROW*BW-1:0]   Q_xmem = '0;
    logic [2:0]          inst_w;
    logic [ROW*BW-1:0]   vector_data_in;
    logic [3:0]          kij;
    logic                readout_start;
    logic                busy;
    logic                done;
`ifdef CORELET_SEQ_PERF_EN
    logic [15:0]         cycle_cnt;
`endif

    corelet_seq dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .cen_xmem       (cen_xmem),
        .wen_xmem       (wen_xmem),
        .A_xmem         (A_xmem),
        .Q_xmem         (Q_xmem),
        .inst_w         (inst_w),
        .vector_data_in (vector_data_in),
        .kij            (kij),
        .readout_start  (readout_start),
        .busy           (busy),
        .done           (done)
`ifdef CORELET_SEQ_PERF_EN
        ,
        .cycle_cnt      (cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural xmem: registered read, data valid one cycle after address
    logic [ROW*BW-1:0] mem [0:(1<<A_BW)-1];
    always @(posedge clk) begin
        if (cen_xmem === 1'b0) Q_xmem <= mem[A_xmem];
    end

    int errors = 0;
    int checks = 0;

    // Expected schedule, index 0 = first LOAD cycle after start
    int           e_phase [N_SCHED];   // 1 load, 2 exec, 0 no access
    int           e_addr  [N_SCHED];
    int           e_kij   [N_SCHED];
    bit           e_rs    [N_SCHED];
    bit           e_busy  [N_SCHED];
    bit           e_done  [N_SCHED];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(inout int idx, input int ph, input int addr, input int k,
                        input bit rs, input bit bsy, input bit dn);
        e_phase[idx] = ph;
        e_addr[idx]  = addr;
        e_kij[idx]   = k;
        e_rs[idx]    = rs;
        e_busy[idx]  = bsy;
        e_done[idx]  = dn;
        idx++;
    endtask

    task automatic build_model();
        int idx = 0;
        for (int k = 0; k < N_KIJ; k++) begin
            for (int j = 0; j < COL; j++)            push(idx, 1, W_BASE + k*COL + j, k, 0, 1, 0);
            for (int j = 0; j < COL; j++)            push(idx, 0, 0, k, 0, 1, 0);
            for (int j = 0; j < N_ACT; j++)          push(idx, 2, j, k, 0, 1, 0);
            for (int j = 0; j < ROW + COL + 4; j++)  push(idx, 0, 0, k, 0, 1, 0);
        end
        for (int j = 0; j < RCYC; j++)               push(idx, 0, 0, N_KIJ-1, (j == 0), 1, 0);
        push(idx, 0, 0, N_KIJ-1, 0, 0, 1);
        push(idx, 0, 0, N_KIJ-1, 0, 0, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".cen"},  cen_xmem, 1'b1);
        chk({tag, ".wen"},  wen_xmem, 1'b1);
        chk({tag, ".A"},    A_xmem, '0);
        chk({tag, ".inst"}, inst_w, 3'b000);
        chk({tag, ".kij"},  kij, 4'd0);
        chk({tag, ".rs"},   readout_start, 1'b0);
        chk({tag, ".busy"}, busy, 1'b0);
        chk({tag, ".done"}, done, 1'b0);
    endtask

    // One run from start; optional re-start pulse or reset at a schedule index
    task automatic run_check(input int restart_at, input int reset_at);
        int exp_inst;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < N_SCHED; i++) begin
            exp_inst = (i == 0) ? 0 : e_phase[i-1];
            chk($sformatf("c%0d.cen", i),  cen_xmem, (e_phase[i] != 0) ? 1'b0 : 1'b1);
            if (e_phase[i] != 0) chk($sformatf("c%0d.A", i), A_xmem, e_addr[i]);
            chk($sformatf("c%0d.wen", i),  wen_xmem, 1'b1);
            chk($sformatf("c%0d.inst", i), inst_w, exp_inst);
            chk($sformatf("c%0d.kij", i),  kij, e_kij[i]);
            chk($sformatf("c%0d.rs", i),   readout_start, e_rs[i]);
            chk($sformatf("c%0d.busy", i), busy, e_busy[i]);
            chk($sformatf("c%0d.done", i), done, e_done[i]);
            chk($sformatf("c%0d.vdi", i),  vector_data_in, Q_xmem);
            if (exp_inst != 0)
                chk($sformatf("c%0d.data", i), vector_data_in, mem[e_addr[i-1]]);
`ifdef CORELET_SEQ_PERF_EN
            if (i == 0)           chk("perf.clear", cycle_cnt, 16'd0);
            if (i == N_SCHED - 1) chk("perf.total", cycle_cnt, 16'(RUN_LEN));
`endif
            if (i == reset_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                chk_reset_vals("midrst");
                return;
            end
            if (i == restart_at) start = 1'b1;
            tick();
            start = 1'b0;
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << A_BW); a++) mem[a] = $urandom;
        build_model();

        reset = 1'b1;
        start = 1'b0;
        for (int r = 0; r < 3; r++) begin
            tick();
            chk_reset_vals("rst");
        end
        reset = 1'b0;
        for (int r = 0; r < 6; r++) begin
            tick();
            chk_reset_vals("idle");
        end

        // Plain full run
        run_check(-1, -1);
        // start re-pulsed during EXEC of kij=3 must be ignored
        run_check(3*PER_KIJ + 2*COL + 8, -1);
        // reset during EXEC of kij=5, then a clean run from kij=0
        run_check(-1, 5*PER_KIJ + 2*COL + 10);
        tick();
        chk_reset_vals("postrst");
        run_check(-1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
